// File: rtl/hgw_sram_tp.sv
// hgw_sram_tp -- two-port SRAM (one write port, one read port, single clock).
//
// Purpose: packet/descriptor buffer with per-byte write enables, a pipelined
// read path of RD_LAT cycles with a read-valid pulse, defined same-address
// collision behaviour, and an optional self-clear pass after reset so the
// array reads as zero without software help.
//
// Optional build macro: HGW_SRAM_TP_PARITY_EN adds one even-parity bit per
// byte, the wr_perr_inj input and the rd_perr output.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active high
//   init_busy    high while reset or self-clear is in progress
//   wr_en        write request
//   wr_addr      write address (AW bits)
//   wr_be        byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data      write data (W bits)
//   rd_en        read request
//   rd_addr      read address (AW bits)
//   rd_data      read data, holds its last value while rd_vld=0
//   rd_vld       one-cycle pulse, rd_data valid
//   wr_perr_inj  (parity build) invert stored parity of the enabled bytes
//   rd_perr      (parity build) per-byte parity error, qualified by rd_vld
//
// FSM states:
//   state   | meaning
//   ST_CLR  | self-clear: zero word ptr each cycle, user ports ignored
//   ST_RUN  | normal read/write operation
module hgw_sram_tp #(
   parameter int D         = 128,
   parameter int W         = 32,
   parameter int RD_LAT    = 1,
   parameter int COLL_MODE = 0,
   parameter int INIT_CLR  = 1,
   localparam int AW       = (D > 1) ? $clog2(D) : 1,
   localparam int BW       = W / 8
) (
   input  logic          clk,
   input  logic          rst,
   output logic          init_busy,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [BW-1:0] wr_be,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   output logic          rd_vld
`ifdef HGW_SRAM_TP_PARITY_EN
   ,
   input  logic          wr_perr_inj,
   output logic [BW-1:0] rd_perr
`endif
);

   typedef enum logic {ST_CLR, ST_RUN} state_t;

   localparam logic [AW-1:0] PTR_LAST = AW'(D - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            run;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_CLR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == PTR_LAST) begin
            state_d = ST_RUN;
            ptr_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (INIT_CLR != 0) ? ST_CLR : ST_RUN;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // rst is folded in so init_busy is already high in the reset cycle itself,
   // before the state register has been forced to ST_CLR.
   assign init_busy = (INIT_CLR != 0) && (rst || (state_q == ST_CLR));
   assign run       = !rst && (state_q == ST_RUN);

   // ------------------------------------------------------ address range
   logic wr_in_rng, rd_in_rng;

   generate
      if (D == (1 << AW)) begin : g_pow2
         assign wr_in_rng = 1'b1;
         assign rd_in_rng = 1'b1;
      end else begin : g_npow2
         assign wr_in_rng = (32'(wr_addr) < 32'(D));
         assign rd_in_rng = (32'(rd_addr) < 32'(D));
      end
   endgenerate

   // ------------------------------------------------- write port mux
   // The self-clear pass owns the write port while in ST_CLR.
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [BW-1:0]   mem_wbe;
   logic [W-1:0]    mem_wdata;
   logic            wr_hit;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wbe   = wr_be;
      mem_wdata = wr_data;
      if (!rst) begin
         if (state_q == ST_CLR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wbe   = '1;
            mem_wdata = '0;
         end else if (wr_en && wr_in_rng) begin
            mem_we = 1'b1;
         end
      end
   end

   assign wr_hit = run && wr_en && wr_in_rng && (wr_addr == rd_addr);

   logic [W-1:0] mem_q [D];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BW; i++) begin
            if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // --------------------------------------------------------- read stage
   logic          rd_fire;
   logic [W-1:0]  rd_old;
   logic [W-1:0]  rd_word;

   assign rd_fire = rd_en && run;
   assign rd_old  = rd_in_rng ? mem_q[rd_addr] : '0;

   // Array read happens before the clock edge commits the write, so rd_old
   // is the pre-write word; write-first mode patches in the enabled bytes.
   always_comb begin
      rd_word = rd_old;
      if (COLL_MODE != 0 && wr_hit) begin
         for (int i = 0; i < BW; i++) begin
            if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
   end

`ifdef HGW_SRAM_TP_PARITY_EN
   logic [BW-1:0] mem_wpar;
   logic [BW-1:0] par_q [D];
   logic [BW-1:0] rd_par;
   logic [BW-1:0] rd_perr_calc;

   always_comb begin
      mem_wpar = '0;
      if (state_q != ST_CLR) begin
         for (int i = 0; i < BW; i++) begin
            mem_wpar[i] = (^wr_data[8*i +: 8]) ^ wr_perr_inj;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BW; i++) begin
            if (mem_wbe[i]) par_q[mem_waddr][i] <= mem_wpar[i];
         end
      end
   end

   always_comb begin
      rd_par = rd_in_rng ? par_q[rd_addr] : '0;
      if (COLL_MODE != 0 && wr_hit) begin
         for (int i = 0; i < BW; i++) begin
            if (wr_be[i]) rd_par[i] = mem_wpar[i];
         end
      end
      for (int i = 0; i < BW; i++) begin
         rd_perr_calc[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
      end
   end
`endif

   // ----------------------------------------------------- read pipeline
   // Stage RD_LAT-1 drives the outputs; its data only loads with a valid
   // word so rd_data holds between reads.
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [W-1:0]      data_q [RD_LAT];
   logic [W-1:0]      data_d [RD_LAT];

   always_comb begin
      vld_d[0]  = rd_fire;
      data_d[0] = rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
         vld_d[k]  = vld_q[k-1];
         data_d[k] = data_q[k-1];
      end
      if (!vld_d[RD_LAT-1]) data_d[RD_LAT-1] = data_q[RD_LAT-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < RD_LAT; k++) data_q[k] <= '0;
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < RD_LAT; k++) data_q[k] <= data_d[k];
      end
   end

   assign rd_vld  = vld_q[RD_LAT-1];
   assign rd_data = data_q[RD_LAT-1];

`ifdef HGW_SRAM_TP_PARITY_EN
   logic [BW-1:0] perr_q [RD_LAT];
   logic [BW-1:0] perr_d [RD_LAT];

   always_comb begin
      perr_d[0] = rd_perr_calc;
      for (int k = 1; k < RD_LAT; k++) perr_d[k] = perr_q[k-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RD_LAT; k++) perr_q[k] <= '0;
      end else begin
         for (int k = 0; k < RD_LAT; k++) perr_q[k] <= perr_d[k];
      end
   end

   assign rd_perr = rd_vld ? perr_q[RD_LAT-1] : '0;
`endif

endmodule

// File: tb/tb_hgw_sram_tp.sv
// Bench for hgw_sram_tp. Instance a: D=128, W=32, RD_LAT=2, read-first,
// self-clear. Instance b: D=12 (out-of-range addresses exist), W=16,
// RD_LAT=1, write-first, no self-clear. Stimulus pushes expected reads into
// per-instance queues; a monitor branch pops and compares on rd_vld.
module tb_hgw_sram_tp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst;

   logic        a_init_busy, a_wr_en, a_rd_en, a_rd_vld;
   logic [6:0]  a_wr_addr, a_rd_addr;
   logic [3:0]  a_wr_be;
   logic [31:0] a_wr_data, a_rd_data;
   logic [3:0]  a_perr_act;

   logic        b_init_busy, b_wr_en, b_rd_en, b_rd_vld;
   logic [3:0]  b_wr_addr, b_rd_addr;
   logic [1:0]  b_wr_be;
   logic [15:0] b_wr_data, b_rd_data;
   logic [1:0]  b_perr_act;

`ifdef HGW_SRAM_TP_PARITY_EN
   logic        a_inj, b_inj;
   logic [3:0]  a_rd_perr;
   logic [1:0]  b_rd_perr;
   assign a_perr_act = a_rd_perr;
   assign b_perr_act = b_rd_perr;
`else
   assign a_perr_act = 4'h0;
   assign b_perr_act = 2'h0;
`endif

   hgw_sram_tp #(.D(128), .W(32), .RD_LAT(2), .COLL_MODE(0), .INIT_CLR(1)) u_a (
      .clk(clk), .rst(rst), .init_busy(a_init_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_vld(a_rd_vld)
`ifdef HGW_SRAM_TP_PARITY_EN
      , .wr_perr_inj(a_inj), .rd_perr(a_rd_perr)
`endif
   );

   hgw_sram_tp #(.D(12), .W(16), .RD_LAT(1), .COLL_MODE(1), .INIT_CLR(0)) u_b (
      .clk(clk), .rst(rst), .init_busy(b_init_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_vld(b_rd_vld)
`ifdef HGW_SRAM_TP_PARITY_EN
      , .wr_perr_inj(b_inj), .rd_perr(b_rd_perr)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  perr;
      int          due;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   done  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      b_wr_en = 1'b0; b_rd_en = 1'b0;
`ifdef HGW_SRAM_TP_PARITY_EN
      a_inj = 1'b0; b_inj = 1'b0;
`endif
   endtask

   task automatic a_wr(input int addr, input logic [31:0] d, input logic [3:0] be);
      a_wr_en = 1'b1; a_wr_addr = 7'(addr); a_wr_data = d; a_wr_be = be;
   endtask

   task automatic a_rd(input int addr, input logic [31:0] exp, input logic [3:0] ep);
      a_rd_en = 1'b1; a_rd_addr = 7'(addr);
      q_a.push_back('{data: exp, perr: ep, due: cyc + 2});
   endtask

   task automatic b_wr(input int addr, input logic [15:0] d, input logic [1:0] be);
      b_wr_en = 1'b1; b_wr_addr = 4'(addr); b_wr_data = d; b_wr_be = be;
   endtask

   task automatic b_rd(input int addr, input logic [15:0] exp);
      b_rd_en = 1'b1; b_rd_addr = 4'(addr);
      q_b.push_back('{data: {16'h0, exp}, perr: 4'h0, due: cyc + 1});
   endtask

   // Measure clear length: cycles of init_busy after rst falls (bounded).
   task automatic measure_clear(input string name);
      int n;
      n = 0;
      while (a_init_busy === 1'b1 && n < 300) begin
         if (n == 120) begin
            a_wr(7, 32'h5555_5555, 4'hF);
            a_rd_en = 1'b1; a_rd_addr = 7'd7;
         end
         tick();
         n++;
      end
      check(name, n, 128);
   endtask

   initial begin
      rst = 1'b1;
      a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_addr = '0; a_rd_addr = '0;
      a_wr_be = '0; a_wr_data = '0;
      b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_addr = '0; b_rd_addr = '0;
      b_wr_be = '0; b_wr_data = '0;
`ifdef HGW_SRAM_TP_PARITY_EN
      a_inj = 1'b0; b_inj = 1'b0;
`endif
      fork
         begin : monitor
            exp_t e;
            while (!done) begin
               @(negedge clk);
               if (a_rd_vld === 1'b1) begin
                  n_vec++;
                  if (q_a.size() == 0) begin
                     n_err++;
                     $display("FAIL a_unexpected_vld: got rd_vld=1 data 0x%0h at cycle %0d, expected no read", a_rd_data, cyc);
                  end else begin
                     e = q_a.pop_front();
                     if (a_rd_data !== e.data || a_perr_act !== e.perr || cyc != e.due) begin
                        n_err++;
                        $display("FAIL a_read: got data 0x%0h perr %b cycle %0d, expected data 0x%0h perr %b cycle %0d",
                                 a_rd_data, a_perr_act, cyc, e.data, e.perr, e.due);
                     end
                  end
               end else if (q_a.size() > 0 && cyc >= q_a[0].due) begin
                  e = q_a.pop_front();
                  n_vec++; n_err++;
                  $display("FAIL a_missing_vld: got rd_vld=0 at cycle %0d, expected data 0x%0h", cyc, e.data);
               end
               if (b_rd_vld === 1'b1) begin
                  n_vec++;
                  if (q_b.size() == 0) begin
                     n_err++;
                     $display("FAIL b_unexpected_vld: got rd_vld=1 data 0x%0h at cycle %0d, expected no read", b_rd_data, cyc);
                  end else begin
                     e = q_b.pop_front();
                     if ({16'h0, b_rd_data} !== e.data || {2'b00, b_perr_act} !== e.perr || cyc != e.due) begin
                        n_err++;
                        $display("FAIL b_read: got data 0x%0h perr %b cycle %0d, expected data 0x%0h perr %b cycle %0d",
                                 b_rd_data, b_perr_act, cyc, e.data, e.perr, e.due);
                     end
                  end
               end else if (q_b.size() > 0 && cyc >= q_b[0].due) begin
                  e = q_b.pop_front();
                  n_vec++; n_err++;
                  $display("FAIL b_missing_vld: got rd_vld=0 at cycle %0d, expected data 0x%0h", cyc, e.data);
               end
            end
         end
         begin : stimulus
            // Reset state.
            repeat (2) @(posedge clk);
            #1;
            check("a_busy_in_rst", a_init_busy, 1);
            check("a_vld_in_rst", a_rd_vld, 0);
            check("a_data_in_rst", a_rd_data, 0);
            check("b_busy_in_rst", b_init_busy, 0);
            check("b_data_in_rst", b_rd_data, 0);
            rst = 1'b0;

            // Self-clear length; a write+read at addr 7 is issued late in the clear.
            measure_clear("a_clear_len");
            check("b_busy_run", b_init_busy, 0);

            for (int i = 0; i < 128; i++) begin
               a_rd(i, 32'h0, 4'h0);
               tick();
            end

            // Latency and back-to-back reads.
            a_wr(5, 32'hDEAD_BEEF, 4'hF); tick();
            a_rd(5, 32'hDEAD_BEEF, 4'h0); tick();
            a_rd(5, 32'hDEAD_BEEF, 4'h0); tick();
            a_rd(6, 32'h0, 4'h0);         tick();
            a_rd(5, 32'hDEAD_BEEF, 4'h0); tick();

            // Byte enables.
            a_wr(9, 32'h1122_3344, 4'hF);   tick();
            a_wr(9, 32'hAABB_CCDD, 4'b0101); tick();
            a_rd(9, 32'h11BB_33DD, 4'h0);   tick();
            a_wr(9, 32'hFFFF_FFFF, 4'b0000); tick();
            a_rd(9, 32'h11BB_33DD, 4'h0);   tick();

            // Read-first collision.
            a_wr(3, 32'hCAFE_F00D, 4'hF); a_rd(3, 32'h0, 4'h0); tick();
            a_rd(3, 32'hCAFE_F00D, 4'h0); tick();

            // Independent ports, different addresses.
            a_wr(20, 32'h0102_0304, 4'hF); a_rd(9, 32'h11BB_33DD, 4'h0); tick();
            a_rd(20, 32'h0102_0304, 4'h0); tick();

            // Top address, single byte on a cleared word.
            a_wr(127, 32'h8BAD_F00D, 4'b1000); tick();
            a_rd(127, 32'h8B00_0000, 4'h0);   tick();

`ifdef HGW_SRAM_TP_PARITY_EN
            a_wr(30, 32'h1234_5678, 4'b0010); a_inj = 1'b1; tick();
            a_rd(30, 32'h0000_5600, 4'b0010); tick();
            a_wr(30, 32'h1234_5678, 4'b0010); tick();
            a_rd(30, 32'h0000_5600, 4'h0);    tick();
`endif
            repeat (4) tick();
            check("a_hold_data", a_rd_data, 32'h0000_5600 & 32'h0 | a_hold_exp());
            check("a_hold_vld", a_rd_vld, 0);

            // Instance b: write-first collision, out-of-range, top address.
            b_wr(4, 16'h1234, 2'b11); tick();
            b_wr(4, 16'hABCD, 2'b01); b_rd(4, 16'h12CD); tick();
            b_rd(4, 16'h12CD); tick();
            b_wr(13, 16'hFFFF, 2'b11); tick();
            b_rd(13, 16'h0000); tick();
            b_wr(11, 16'hBEEF, 2'b11); b_rd(15, 16'h0000); tick();
            b_rd(11, 16'hBEEF); tick();
            b_wr(0, 16'h5A5A, 2'b11); b_rd(0, 16'h5A5A); tick();
            repeat (3) tick();
            check("b_hold_data", b_rd_data, 32'h5A5A);

            // Restart the clear at ptr=60.
            rst = 1'b1; tick();
            rst = 1'b0;
            repeat (60) tick();
            check("a_busy_at_60", a_init_busy, 1);
            rst = 1'b1; tick();
            check("a_busy_restart_rst", a_init_busy, 1);
            check("b_busy_restart_rst", b_init_busy, 0);
            rst = 1'b0;
            measure_clear("a_clear_len_restart");

            a_rd(5, 32'h0, 4'h0);   tick();
            a_rd(127, 32'h0, 4'h0); tick();
            a_rd(7, 32'h0, 4'h0);   tick();
            b_rd(11, 16'hBEEF);     tick();
            repeat (5) tick();

            check("a_queue_drained", q_a.size(), 0);
            check("b_queue_drained", q_b.size(), 0);
            done = 1'b1;
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Last word read on instance a before the hold check.
   function automatic logic [31:0] a_hold_exp();
`ifdef HGW_SRAM_TP_PARITY_EN
      return 32'h0000_5600;
`else
      return 32'h8B00_0000;
`endif
   endfunction

endmodule

// File: doc/hgw_sram_tp.md
Name: hgw_sram_tp

Overview:
- Parametrised two-port SRAM: one write port, one read port, single clock.
- Successor to the team's single-port flop/BRAM SRAM wrapper. Adds:
  - independent read/write ports with per-byte write enables;
  - configurable read latency with a read-valid flag;
  - defined same-address collision behaviour;
  - an optional self-clear state machine after reset.
- Used for packet/descriptor buffers where the memory must read as zero after reset without software clearing it.

Parameters:
- D, 128, depth in words; any value ≥2. AW = $clog2(D).
- W, 32, data width; must be a multiple of 8. BW = W/8.
- RD_LAT, 1, read latency in cycles; legal 1..3.
- COLL_MODE, 0, same-cycle same-address write/read: 0 = read-first (old data), 1 = write-first (merged new data).
- INIT_CLR, 1, 1 = clear all D words to zero after reset; 0 = no clear.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- init_busy  out  1  high while reset or self-clear is in progress.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_be  in  BW  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  in  W  write data.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_data  out  W  read data.
- rd_vld  out  1  one-cycle pulse; rd_data is valid.
- wr_perr_inj  in  1  present only with HGW_SRAM_TP_PARITY_EN.
- rd_perr  out  BW  present only with HGW_SRAM_TP_PARITY_EN.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values while rst=1: rd_data=0, rd_vld=0, read pipeline flushed, rd_perr=0, clear pointer=0.
  - init_busy=1 if INIT_CLR=1; init_busy=0 if INIT_CLR=0.
- FSM states: CLR, RUN.
  - rst forces CLR if INIT_CLR=1, RUN otherwise.
  - In CLR: write zero to word ptr each cycle after rst falls; ptr increments 0..D-1.
  - At ptr=D-1, go to RUN next cycle. init_busy falls exactly D cycles after the first cycle with rst=0.
  - rst asserted mid-clear restarts from ptr=0.
- During CLR: wr_en and rd_en are ignored (dropped, not queued); rd_vld stays 0.
- Write in RUN: with wr_en=1, for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i at the clock edge. Other bytes are unchanged. wr_be=0 means no change.
- Read in RUN: rd_en=1 samples rd_addr.
  - rd_vld=1 and rd_data=word exactly RD_LAT cycles later.
  - Back-to-back reads are fully pipelined at one read per cycle.
  - When rd_vld=0, rd_data holds its last value.
- Collision (wr_en & rd_en & same address, same cycle):
  - COLL_MODE=0: returns the pre-write word.
  - COLL_MODE=1: returns the old word with the enabled bytes replaced by wr_data.
  - Any read issued on a later cycle returns the new data.
- Out-of-range address (addr ≥ D, only when D is not a power of 2): the write is ignored; the read returns 0 with rd_vld=1.
- Simultaneous rd and wr at different addresses: independent, no stall.

Optional Feature:
- Macro: HGW_SRAM_TP_PARITY_EN.
- When defined:
  - Each byte stores one even-parity bit, written with its byte.
  - Self-clear stores parity 0.
  - wr_perr_inj=1 with a write inverts the stored parity of the enabled bytes.
  - rd_perr[i]=1 with rd_vld when byte i fails the check; otherwise 0.
  - Collision bypass data (COLL_MODE=1) carries the computed parity, so rd_perr=0 unless injected.
- When not defined: no parity storage; wr_perr_inj and rd_perr ports are absent.

Test Plan:
1. D=128, INIT_CLR=1: pulse rst 2 cycles → init_busy high for 128 cycles after rst falls. Then read all addresses → every rd_data=0. A write issued during CLR is dropped (the later read returns 0).
2. RD_LAT=2: write 0xDEADBEEF to addr 5, then rd_en at addr 5 on cycle T → rd_vld=1 with 0xDEADBEEF at T+2. Reads of addr 5,6,5 on consecutive cycles → three consecutive rd_vld pulses.
3. Byte enables: write 0x11223344 to addr 9, then 0xAABBCCDD with wr_be=4'b0101 → read returns 0x11BB33DD.
4. Collision: addr 3 holds 0x0; same cycle wr 0xCAFEF00D (be=4'hF) and rd addr 3.
   - COLL_MODE=0 → read returns 0x0; next read returns 0xCAFEF00D.
   - COLL_MODE=1 → read returns 0xCAFEF00D.
5. rst asserted at clear ptr=60 → ptr restarts at 0; init_busy stays high for a further full 128 cycles after rst falls. No rd_vld occurs during clear.
6. With HGW_SRAM_TP_PARITY_EN: write 0x12345678 with wr_perr_inj=1, be=4'b0010 → read gives rd_perr=4'b0010. Rewrite with inj=0 → rd_perr=0.
